square_wave_gen: RTL and testbench



---
 rtl/sqgen_pkg.sv | 22 ++
 rtl/sqgen_bit_src.sv | 56 +++++
 rtl/square_wave_gen.sv | 121 ++++++++++++
 tb/tb_square_wave_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sqgen_pkg.sv
// Shared types and constants for the square-wave test-stimulus generator.
// PRBS7 constants are used only when SQGEN_PRBS_EN is defined.
package sqgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // PRBS7 x^7 + x^6 + 1, shift-left Fibonacci form; output taken from bit 6
  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  localparam int MIN_PERIOD = 1;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
  endfunction

endpackage

// File: rtl/sqgen_bit_src.sv
// Symbol source: LSB-first rotating pattern, plus a PRBS7 when SQGEN_PRBS_EN is defined.
// load_sym is the symbol that will be current immediately after a load.
module sqgen_bit_src
  import sqgen_pkg::*;
#(
  parameter int PAT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 advance,
`ifdef SQGEN_PRBS_EN
  input  logic                 prbs_sel,
`endif
  input  logic [PAT_WIDTH-1:0] pattern,
  output logic                 sym,
  output logic                 load_sym
);

  logic [PAT_WIDTH-1:0] pat_q;

  // load and advance together: the loaded symbol was consumed by the start-cycle sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
    end else if (load) begin
      pat_q <= advance ? {pattern[0], pattern[PAT_WIDTH-1:1]} : pattern;
    end else if (advance) begin
      pat_q <= {pat_q[0], pat_q[PAT_WIDTH-1:1]};
    end
  end

`ifdef SQGEN_PRBS_EN
  logic [6:0] prbs_q;
  logic       sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prbs_q <= PRBS7_SEED;
      sel_q  <= 1'b0;
    end else if (load) begin
      sel_q  <= prbs_sel;
      prbs_q <= advance ? prbs7_step(PRBS7_SEED) : PRBS7_SEED;
    end else if (advance) begin
      prbs_q <= prbs7_step(prbs_q);
    end
  end

  assign sym      = sel_q ? prbs_q[6] : pat_q[0];
  assign load_sym = prbs_sel ? PRBS7_SEED[6] : pattern[0];
`else
  assign sym      = pat_q[0];
  assign load_sym = pattern[0];
`endif

endmodule

// File: rtl/square_wave_gen.sv
// Two-level sample generator: CNT_NUM samples per start, symbol held bit_period clocks.
// Optional PRBS7 symbol source and prbs_sel port under SQGEN_PRBS_EN.
module square_wave_gen
  import sqgen_pkg::*;
#(
  parameter int          OUT_WIDTH = 18,
  parameter int          CNT_WIDTH = 32,
  parameter logic [31:0] CNT_NUM   = 32'd6000,
  parameter int          PAT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic        [CNT_WIDTH-1:0] bit_period,
  input  logic signed [OUT_WIDTH-1:0] amp_hi,
  input  logic signed [OUT_WIDTH-1:0] amp_lo,
  input  logic        [PAT_WIDTH-1:0] pattern,
`ifdef SQGEN_PRBS_EN
  input  logic                        prbs_sel,
`endif
  output logic signed [OUT_WIDTH-1:0] dat,
  output logic                        dat_valid,
  output logic                        bit_out,
  output logic        [CNT_WIDTH-1:0] edge_cnt,
  output logic                        busy,
  output logic                        done
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(CNT_NUM - 32'd1);
  localparam logic [CNT_WIDTH-1:0] MIN_PER  = CNT_WIDTH'(MIN_PERIOD);

  state_t                      st, st_nxt;
  logic        [CNT_WIDTH-1:0] per_q, sc, tmr;
  logic signed [OUT_WIDTH-1:0] amp_hi_q, amp_lo_q;
  logic                        emit;
  logic                        sym, load_sym, sym_now;
  logic        [CNT_WIDTH-1:0] per_in, per_sel, pos;
  logic                        wrap, adv;
  logic signed [OUT_WIDTH-1:0] hi_sel, lo_sel;

  // The start cycle itself emits sample 0 from the new configuration, so a
  // restart mid-run keeps dat_valid continuous.
  always_comb begin
    st_nxt = st;
    emit   = 1'b0;
    case (st)
      IDLE: st_nxt = IDLE;
      RUN: begin
        if (sc == LAST_IDX) st_nxt = FIN;
        else                emit   = 1'b1;
      end
      FIN:     st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
    if (start) begin
      st_nxt = RUN;
      emit   = 1'b1;
    end
  end

  assign per_in  = (bit_period == '0) ? MIN_PER : bit_period;
  assign per_sel = start ? per_in : per_q;
  assign pos     = start ? '0 : tmr;
  assign wrap    = (pos == per_sel - MIN_PER);
  assign adv     = emit && wrap;
  assign sym_now = start ? load_sym : sym;
  assign hi_sel  = start ? amp_hi : amp_hi_q;
  assign lo_sel  = start ? amp_lo : amp_lo_q;

  sqgen_bit_src #(
    .PAT_WIDTH(PAT_WIDTH)
  ) u_bit_src (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start),
    .advance (adv),
`ifdef SQGEN_PRBS_EN
    .prbs_sel(prbs_sel),
`endif
    .pattern (pattern),
    .sym     (sym),
    .load_sym(load_sym)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      per_q     <= MIN_PER;
      amp_hi_q  <= '0;
      amp_lo_q  <= '0;
      sc        <= '0;
      tmr       <= '0;
      edge_cnt  <= '0;
      dat       <= '0;
      dat_valid <= 1'b0;
      bit_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      st   <= st_nxt;
      busy <= (st_nxt == RUN);
      done <= (st_nxt == FIN);
      if (start) begin
        per_q    <= per_in;
        amp_hi_q <= amp_hi;
        amp_lo_q <= amp_lo;
        sc       <= '0;
        edge_cnt <= '0;
      end else if (emit) begin
        sc <= sc + CNT_WIDTH'(1);
        // bit_out still holds the previously emitted symbol here
        if (sym_now != bit_out) edge_cnt <= edge_cnt + CNT_WIDTH'(1);
      end
      if (emit) tmr <= wrap ? '0 : pos + CNT_WIDTH'(1);
      dat       <= emit ? (sym_now ? hi_sel : lo_sel) : '0;
      dat_valid <= emit;
      bit_out   <= emit & sym_now;
    end
  end

endmodule

// File: tb/tb_square_wave_gen.sv
// Directed bench for square_wave_gen: vector table of full runs plus restart and mid-run reset.
// Exercises the PRBS7 source when SQGEN_PRBS_EN is defined.
module tb_square_wave_gen;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic        [31:0] bit_period;
  logic signed [17:0] amp_hi, amp_lo;
  logic        [15:0] pattern;
`ifdef SQGEN_PRBS_EN
  logic               prbs_sel;
`endif
  logic signed [17:0] dat;
  logic               dat_valid, bit_out, busy, done;
  logic        [31:0] edge_cnt;

  int checks   = 0;
  int failures = 0;
  int prbs_bits[127];

  typedef struct {
    logic        [15:0] pat;
    int                 per;
    logic signed [17:0] hi;
    logic signed [17:0] lo;
    int                 exp_edges;
  } vec_t;

  vec_t vecs[5];

  square_wave_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_period(bit_period),
    .amp_hi    (amp_hi),
    .amp_lo    (amp_lo),
    .pattern   (pattern),
`ifdef SQGEN_PRBS_EN
    .prbs_sel  (prbs_sel),
`endif
    .dat       (dat),
    .dat_valid (dat_valid),
    .bit_out   (bit_out),
    .edge_cnt  (edge_cnt),
    .busy      (busy),
    .done      (done)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic model_sym(input logic [15:0] pat, input int per, input int sel, input int i);
    int pe;
    int j;
    pe = (per == 0) ? 1 : per;
    j  = i / pe;
    if (sel != 0) return prbs_bits[j % 127] != 0;
    return pat[j % 16];
  endfunction

  // Drives the start cycle; on return the bench sits in cycle 1 of the new run.
  task automatic launch(input logic [15:0] pat, input int per, input logic signed [17:0] hi,
                        input logic signed [17:0] lo, input int sel);
    pattern    = pat;
    bit_period = per;
    amp_hi     = hi;
    amp_lo     = lo;
`ifdef SQGEN_PRBS_EN
    prbs_sel   = sel[0];
`endif
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Compares every output of cycles 1..stop_c of a run against the model.
  task automatic watch(input logic [15:0] pat, input int per, input logic signed [17:0] hi,
                       input logic signed [17:0] lo, input int sel, input int stop_c,
                       output int bad, output int first_bad);
    bad       = 0;
    first_bad = 0;
    for (int c = 1; c <= stop_c; c++) begin
      logic               ev;
      logic               s;
      logic signed [17:0] ed;
      ev = (c <= 6000);
      s  = ev ? model_sym(pat, per, sel, c - 1) : 1'b0;
      ed = ev ? (s ? hi : lo) : 18'sd0;
      if (dat_valid !== ev || dat !== ed || bit_out !== s || busy !== ev || done !== (c == 6001)) begin
        if (bad == 0) first_bad = c;
        bad++;
      end
      if (c < stop_c) tick();
    end
  endtask

  task automatic full_run(input string name, input logic [15:0] pat, input int per,
                          input logic signed [17:0] hi, input logic signed [17:0] lo,
                          input int sel, input int exp_edges);
    int bad, first_bad;
    launch(pat, per, hi, lo, sel);
    watch(pat, per, hi, lo, sel, 6003, bad, first_bad);
    check({name, "_stream_bad_cycles"}, bad, 0);
    if (bad != 0) check({name, "_first_bad_cycle"}, first_bad, 0);
    check({name, "_edge_cnt"}, edge_cnt, exp_edges);
    tick();
    check({name, "_idle_busy_done_valid"}, {busy, done, dat_valid}, 0);
  endtask

  initial begin
    int bad, first_bad;

    vecs[0] = '{16'hAAAA, 10, 18'sd1000,   -18'sd1000,   599};
    vecs[1] = '{16'hFFFF,  5, 18'sd2000,   -18'sd3,        0};
    vecs[2] = '{16'h00FF,  0, 18'sd1000,   -18'sd1000,   749};
    vecs[3] = '{16'h0F0F,  3, -18'sd500,    18'sd700,    499};
    vecs[4] = '{16'h0001,  7, 18'sd131071, -18'sd131072, 107};

    for (int n = 0; n < 127; n++)
      prbs_bits[n] = (n < 7) ? 1 : (prbs_bits[n-7] ^ prbs_bits[n-6]);

    rst_n      = 1'b0;
    start      = 1'b0;
    bit_period = 32'd0;
    amp_hi     = 18'sd0;
    amp_lo     = 18'sd0;
    pattern    = 16'h0;
`ifdef SQGEN_PRBS_EN
    prbs_sel   = 1'b0;
`endif
    tick();
    tick();
    check("rst_dat", dat, 0);
    check("rst_dat_valid", dat_valid, 0);
    check("rst_bit_out", bit_out, 0);
    check("rst_edge_cnt", edge_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++)
      full_run($sformatf("vec%0d", v), vecs[v].pat, vecs[v].per, vecs[v].hi, vecs[v].lo, 0,
               vecs[v].exp_edges);

    // Restart halfway through: dat_valid continuous, no done for the first run.
    launch(vecs[0].pat, vecs[0].per, vecs[0].hi, vecs[0].lo, 0);
    watch(vecs[0].pat, vecs[0].per, vecs[0].hi, vecs[0].lo, 0, 3000, bad, first_bad);
    check("restart_first_half_bad", bad, 0);
    launch(vecs[2].pat, vecs[2].per, vecs[2].hi, vecs[2].lo, 0);
    check("restart_edge_cnt_cleared", edge_cnt, 0);
    watch(vecs[2].pat, vecs[2].per, vecs[2].hi, vecs[2].lo, 0, 6003, bad, first_bad);
    check("restart_second_run_bad", bad, 0);
    if (bad != 0) check("restart_first_bad_cycle", first_bad, 0);
    check("restart_edge_cnt", edge_cnt, 749);
    tick();

    // Reset in the middle of a run.
    launch(vecs[0].pat, vecs[0].per, vecs[0].hi, vecs[0].lo, 0);
    watch(vecs[0].pat, vecs[0].per, vecs[0].hi, vecs[0].lo, 0, 2000, bad, first_bad);
    check("midrst_pre_bad", bad, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_dat", dat, 0);
    check("midrst_dat_valid", dat_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_bit_out", bit_out, 0);
    check("midrst_edge_cnt", edge_cnt, 0);
    tick();
    tick();
    check("midrst_no_done", done, 0);
    rst_n = 1'b1;
    tick();
    full_run("after_rst", vecs[0].pat, vecs[0].per, vecs[0].hi, vecs[0].lo, 0, 599);

`ifdef SQGEN_PRBS_EN
    begin
      int exp_e;
      int ones;
      exp_e = 0;
      ones  = 0;
      for (int i = 1; i < 6000; i++)
        if (model_sym(16'h0, 1, 1, i) != model_sym(16'h0, 1, 1, i - 1)) exp_e++;
      for (int n = 0; n < 127; n++) ones += prbs_bits[n];
      check("prbs_model_ones", ones, 64);
      full_run("prbs", 16'hAAAA, 1, 18'sd1000, -18'sd1000, 1, exp_e);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
